islip_grant_arbiter: RTL and testbench

- Round-robin grant arbiter for one output port of the p-iSLIP scheduler.
- Picks one of N input requests, starting from a rotating pointer, and drives a registered one-hot grant.
- Holds the grant until the input side accepts it, rejects it, or a timeout expires.
- Advances its pointer only on accept, following the iSLIP rule, so starvation freedom is preserved.

---
 rtl/islip_pkg.sv | 21 ++
 rtl/islip_grant_arbiter_if.sv | 26 ++
 rtl/simple_priority_encoder.sv | 14 +
 rtl/islip_grant_arbiter.sv | 132 +++++++++++++
 tb/tb_islip_grant_arbiter.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/islip_pkg.sv
// Shared types and helpers for the p-iSLIP grant and accept arbiters.
package islip_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } arb_state_e;

  localparam int OH_MAX = 64;

  // Converts a one-hot vector to its index by OR-ing the positions of set bits.
  function automatic logic [31:0] onehot_to_idx(input logic [OH_MAX-1:0] oh);
    logic [31:0] idx;
    idx = 32'd0;
    for (int i = 0; i < OH_MAX; i++) begin
      idx = idx | (oh[i] ? 32'(i) : 32'd0);
    end
    return idx;
  endfunction

endpackage

// File: rtl/islip_grant_arbiter_if.sv
// Request/grant bundle between one output port arbiter and the input side.
interface islip_grant_arbiter_if #(
  parameter int N = 25
) ();
  localparam int PW = $clog2(N);

  logic          en;
  logic [N-1:0]  in_request;
  logic          in_accept;
  logic          in_reject;
  logic [N-1:0]  out_grant;
  logic [PW-1:0] out_grant_idx;
  logic          out_valid;
  logic          out_timeout;
  logic [PW-1:0] out_pointer;

  modport master (
    output en, in_request, in_accept, in_reject,
    input  out_grant, out_grant_idx, out_valid, out_timeout, out_pointer
  );

  modport slave (
    input  en, in_request, in_accept, in_reject,
    output out_grant, out_grant_idx, out_valid, out_timeout, out_pointer
  );
endinterface

// File: rtl/simple_priority_encoder.sv
// Isolates the lowest set bit of a request vector as a one-hot grant.
module simple_priority_encoder #(
  parameter int W = 4
) (
  input  logic [W-1:0] req_i,
  output logic [W-1:0] gnt_o,
  output logic         any_o
);

  // Two's-complement trick keeps only the least significant set bit.
  assign gnt_o = req_i & (~req_i + W'(1));
  assign any_o = |req_i;

endmodule

// File: rtl/islip_grant_arbiter.sv
// Round-robin grant arbiter for one output port; the pointer moves only
// on accept so that iSLIP keeps its starvation freedom.
module islip_grant_arbiter
  import islip_pkg::*;
#(
  parameter int N       = 25,
  parameter int TIMEOUT = 8
) (
  input logic                 clk,
  input logic                 rst_n,
  islip_grant_arbiter_if.slave bus
);

  localparam int PW = $clog2(N);
  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e    state_q, state_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic [PW-1:0] idx_q, idx_d;
  logic [N-1:0]  grant_q, grant_d;
  logic          valid_q, valid_d;
  logic          timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic [N-1:0]  mask_s, masked_s, masked_gnt_s, raw_gnt_s, pick_s;
  logic          masked_any_s, raw_any_s;
  logic [PW-1:0] pick_idx_s;

  // Thermometer mask: requesters at or above the pointer get first chance.
  always_comb begin
    mask_s = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      mask_s[i] = (i >= int'(ptr_q));
    end
  end

  assign masked_s = bus.in_request & mask_s;

  simple_priority_encoder #(.W(N)) u_pe_masked (
    .req_i (masked_s),
    .gnt_o (masked_gnt_s),
    .any_o (masked_any_s)
  );

  simple_priority_encoder #(.W(N)) u_pe_raw (
    .req_i (bus.in_request),
    .gnt_o (raw_gnt_s),
    .any_o (raw_any_s)
  );

  assign pick_s     = masked_any_s ? masked_gnt_s : raw_gnt_s;
  assign pick_idx_s = PW'(onehot_to_idx(OH_MAX'(pick_s)));

  // Next-state and output logic; response beats timeout, accept beats reject.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    grant_d   = grant_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    cnt_d     = cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.en && raw_any_s) begin
          grant_d = pick_s;
          idx_d   = pick_idx_s;
          valid_d = 1'b1;
          cnt_d   = {CW{1'b0}};
          state_d = WAIT;
        end else begin
          grant_d = {N{1'b0}};
          idx_d   = {PW{1'b0}};
          valid_d = 1'b0;
          cnt_d   = {CW{1'b0}};
        end
      end
      WAIT: begin
        if (bus.in_accept || bus.in_reject || (cnt_q == CW'(TIMEOUT - 1))) begin
          grant_d   = {N{1'b0}};
          idx_d     = {PW{1'b0}};
          valid_d   = 1'b0;
          cnt_d     = {CW{1'b0}};
          state_d   = IDLE;
          timeout_d = !bus.in_accept && !bus.in_reject;
          if (bus.in_accept) begin
            ptr_d = (idx_q == PW'(N - 1)) ? {PW{1'b0}} : idx_q + PW'(1);
          end else begin
            ptr_d = ptr_q;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        grant_d = {N{1'b0}};
        idx_d   = {PW{1'b0}};
        valid_d = 1'b0;
        cnt_d   = {CW{1'b0}};
        state_d = IDLE;
      end
    endcase
  end

  // State, pointer, counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= {PW{1'b0}};
      idx_q     <= {PW{1'b0}};
      grant_q   <= {N{1'b0}};
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      cnt_q     <= {CW{1'b0}};
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      idx_q     <= idx_d;
      grant_q   <= grant_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.out_grant     = grant_q;
  assign bus.out_grant_idx = idx_q;
  assign bus.out_valid     = valid_q;
  assign bus.out_timeout   = timeout_q;
  assign bus.out_pointer   = ptr_q;

endmodule

// File: tb/tb_islip_grant_arbiter.sv
// Scoreboard bench: directed N=4/TIMEOUT=4 cases plus an N=25 random soak.
module tb_islip_grant_arbiter;

  logic clk;
  logic rst_n;

  islip_grant_arbiter_if #(.N(4))  a4 ();
  islip_grant_arbiter_if #(.N(25)) a25 ();

  islip_grant_arbiter #(.N(4), .TIMEOUT(4)) dut4 (
    .clk (clk), .rst_n (rst_n), .bus (a4)
  );

  islip_grant_arbiter #(.N(25), .TIMEOUT(3)) dut25 (
    .clk (clk), .rst_n (rst_n), .bus (a25)
  );

  int checks   = 0;
  int failures = 0;
  int mptr4    = 0;
  int mptr25   = 0;
  int last4    = 0;
  logic [31:0] exp_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rr_pick(input logic [31:0] req, input int ptr, input int n);
    int j;
    for (int k = 0; k < n; k++) begin
      j = (ptr + k) % n;
      if (req[j]) return 32'd1 << j;
    end
    return 32'd0;
  endfunction

  function automatic int oh_idx(input logic [31:0] oh);
    for (int k = 0; k < 32; k++) begin
      if (oh[k]) return k;
    end
    return 0;
  endfunction

  task automatic g4(input logic [3:0] req, input string tag);
    logic [31:0] e;
    a4.en = 1'b1;
    a4.in_request = req;
    exp_q.push_back(rr_pick(32'(req), mptr4, 4));
    @(negedge clk);
    a4.en = 1'b0;
    e = exp_q.pop_front();
    last4 = oh_idx(e);
    check_val({tag, "_grant"}, 32'(a4.out_grant), e);
    check_val({tag, "_idx"}, 32'(a4.out_grant_idx), 32'(last4));
    check_val({tag, "_valid"}, 32'(a4.out_valid), 32'd1);
  endtask

  task automatic r4(input logic acc, input logic rej, input string tag);
    a4.in_accept = acc;
    a4.in_reject = rej;
    @(negedge clk);
    a4.in_accept = 1'b0;
    a4.in_reject = 1'b0;
    if (acc) mptr4 = (last4 == 3) ? 0 : last4 + 1;
    check_val({tag, "_valid0"}, 32'(a4.out_valid), 32'd0);
    check_val({tag, "_grant0"}, 32'(a4.out_grant), 32'd0);
    check_val({tag, "_tmo0"}, 32'(a4.out_timeout), 32'd0);
    check_val({tag, "_ptr"}, 32'(a4.out_pointer), 32'(mptr4));
  endtask

  initial begin
    int vcnt;
    int s5, s17, choice, gi;
    logic [31:0] req, e;

    rst_n = 1'b0;
    a4.en = 1'b0;  a4.in_request = '0;  a4.in_accept = 1'b0;  a4.in_reject = 1'b0;
    a25.en = 1'b0; a25.in_request = '0; a25.in_accept = 1'b0; a25.in_reject = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_grant", 32'(a4.out_grant), 32'd0);
    check_val("rst_idx", 32'(a4.out_grant_idx), 32'd0);
    check_val("rst_valid", 32'(a4.out_valid), 32'd0);
    check_val("rst_tmo", 32'(a4.out_timeout), 32'd0);
    check_val("rst_ptr", 32'(a4.out_pointer), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    g4(4'b1010, "t1");  r4(1'b1, 1'b0, "t1acc");
    check_val("t1_ptr2", 32'(a4.out_pointer), 32'd2);
    g4(4'b0011, "t2wrap"); r4(1'b1, 1'b0, "t2acc");
    g4(4'b1000, "t3idx3"); r4(1'b1, 1'b0, "t3acc");
    check_val("t3_ptrwrap", 32'(a4.out_pointer), 32'd0);
    g4(4'b1001, "t3b");  r4(1'b1, 1'b0, "t3bacc");

    // Timeout: grant held exactly TIMEOUT cycles, one pulse, pointer kept.
    g4(4'b0100, "t4");
    vcnt = 1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (a4.out_valid) vcnt++;
      else break;
    end
    check_val("t4_lifetime", 32'(vcnt), 32'd4);
    check_val("t4_tmo_pulse", 32'(a4.out_timeout), 32'd1);
    check_val("t4_ptr", 32'(a4.out_pointer), 32'(mptr4));
    @(negedge clk);
    check_val("t4_tmo_once", 32'(a4.out_timeout), 32'd0);

    g4(4'b0100, "t5");
    @(negedge clk);
    check_val("t5_held", 32'(a4.out_valid), 32'd1);
    r4(1'b0, 1'b1, "t5rej");

    g4(4'b0100, "t6");  r4(1'b1, 1'b1, "t6both");
    check_val("t6_ptr3", 32'(a4.out_pointer), 32'd3);

    g4(4'b0001, "t7");
    a4.in_request = 4'b0000;
    @(negedge clk);
    check_val("t7_hold_grant", 32'(a4.out_grant), 32'd1);
    check_val("t7_hold_valid", 32'(a4.out_valid), 32'd1);
    r4(1'b1, 1'b0, "t7acc");

    g4(4'b0010, "t8");
    #2 rst_n = 1'b0;
    #1;
    mptr4 = 0;
    check_val("t8_arst_grant", 32'(a4.out_grant), 32'd0);
    check_val("t8_arst_valid", 32'(a4.out_valid), 32'd0);
    check_val("t8_arst_idx", 32'(a4.out_grant_idx), 32'd0);
    check_val("t8_arst_ptr", 32'(a4.out_pointer), 32'd0);
    a4.in_request = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random soak with requesters 5 and 17 always asking.
    mptr25 = 0; s5 = 0; s17 = 0;
    for (int t = 0; t < 300; t++) begin
      req = ($urandom() & 32'h01FF_FFFF) | (32'd1 << 5) | (32'd1 << 17);
      a25.en = 1'b1;
      a25.in_request = req[24:0];
      exp_q.push_back(rr_pick(req, mptr25, 25));
      @(negedge clk);
      a25.en = 1'b0;
      a25.in_request = 25'($urandom());
      e = exp_q.pop_front();
      gi = oh_idx(e);
      check_val("soak_grant", 32'(a25.out_grant), e);
      check_val("soak_onehot", 32'($countones(a25.out_grant)), 32'd1);
      check_val("soak_subset", 32'(a25.out_grant) & ~req, 32'd0);
      check_val("soak_idx", 32'(a25.out_grant_idx), 32'(gi));
      if (gi == 5) s5 = 0;
      if (gi == 17) s17 = 0;
      choice = $urandom_range(0, 3);
      if (choice <= 1) begin
        a25.in_accept = 1'b1;
        @(negedge clk);
        a25.in_accept = 1'b0;
        mptr25 = (gi == 24) ? 0 : gi + 1;
        if (gi != 5) s5++;
        if (gi != 17) s17++;
        check_val("soak_starve", 32'((s5 <= 25) && (s17 <= 25)), 32'd1);
      end else if (choice == 2) begin
        a25.in_reject = 1'b1;
        @(negedge clk);
        a25.in_reject = 1'b0;
      end else begin
        repeat (2) @(negedge clk);
        check_val("soak_held", 32'(a25.out_valid), 32'd1);
        @(negedge clk);
        check_val("soak_tmo", 32'(a25.out_timeout), 32'd1);
      end
      check_val("soak_drop", 32'(a25.out_valid), 32'd0);
      check_val("soak_ptr", 32'(a25.out_pointer), 32'(mptr25));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
